hamming_dec_arbiter: RTL

Round-robin arbiter and sequencer that shares one Hamming(7,4) single-error-correcting decode stage among N_REQ requesters. Each requester offers 7-bit codewords over a valid/ready handshake. The block grants one requester per cycle, registers the codeword and decodes it. It then presents corrected data, syndrome and requester ID downstream with valid/ready backpressure. It also keeps a saturating corrected-error counter per requester for link-health monitoring.

---
 rtl/hamming_dec_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hamming_dec_arbiter.sv
// Round-robin arbiter feeding a shared Hamming(7,4) SEC decode stage.
// Two-slot pipeline (capture S1, output S2) with per-requester saturating error counters.
module hamming_dec_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [7*N_REQ-1:0]     req_code,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_data,
    output logic [2:0]             out_syndrome,
    output logic                   out_corrected,
    output logic [ID_W-1:0]        out_id,
    output logic [CNT_W*N_REQ-1:0] err_count,
    input  logic                   clr_count
);

    logic             r_s1_valid;
    logic [6:0]       r_s1_code;
    logic [ID_W-1:0]  r_s1_id;
    logic [ID_W-1:0]  r_ptr;
    logic             r_out_valid;
    logic [3:0]       r_out_data;
    logic [2:0]       r_out_syn;
    logic             r_out_corr;
    logic [ID_W-1:0]  r_out_id;
    logic [CNT_W-1:0] r_cnt [N_REQ];

    logic [N_REQ-1:0] w_rot;
    logic             w_any;
    logic [ID_W-1:0]  w_grant;
    int               w_sum;
    logic [6:0]       w_code;
    logic             w_s2_adv;
    logic             w_s1_can;
    logic             w_accept;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [2:0]       w_syn;
    logic [3:0]       w_dflip;
    logic [3:0]       w_data;
    logic             w_cnt_inc;

    // Requests rotated so that offset 0 is the current pointer.
    assign w_rot = N_REQ'({req_valid, req_valid} >> r_ptr);

    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_sum   = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                w_sum = int'(r_ptr) + k;
                if (w_sum >= int'(N_REQ)) begin
                    w_sum = w_sum - int'(N_REQ);
                end
                w_grant = ID_W'(w_sum);
            end
        end
    end

    always_comb begin
        w_code = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_grant == ID_W'(i)) begin
                w_code = req_code[7*i +: 7];
            end
        end
    end

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_can  = !r_s1_valid || w_s2_adv;
    assign w_accept  = w_any && w_s1_can && rst_n;
    assign req_ready = w_accept ? (N_REQ'(1) << w_grant) : '0;
    assign w_ptr_nxt = (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + ID_W'(1);

    assign w_syn[0] = ^{r_s1_code[6], r_s1_code[4], r_s1_code[2], r_s1_code[0]};
    assign w_syn[1] = ^{r_s1_code[6], r_s1_code[5], r_s1_code[2], r_s1_code[1]};
    assign w_syn[2] = ^{r_s1_code[6], r_s1_code[5], r_s1_code[4], r_s1_code[3]};

    // Only syndromes pointing at data positions flip a data bit.
    always_comb begin
        w_dflip = 4'b0000;
        case (w_syn)
            3'd3:    w_dflip = 4'b0001;
            3'd5:    w_dflip = 4'b0010;
            3'd6:    w_dflip = 4'b0100;
            3'd7:    w_dflip = 4'b1000;
            default: w_dflip = 4'b0000;
        endcase
    end

    assign w_data    = {r_s1_code[6:4], r_s1_code[2]} ^ w_dflip;
    assign w_cnt_inc = w_s2_adv && r_s1_valid && (w_syn != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_code   <= '0;
            r_s1_id     <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_syn   <= '0;
            r_out_corr  <= 1'b0;
            r_out_id    <= '0;
        end else begin
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_data;
                    r_out_syn  <= w_syn;
                    r_out_corr <= (w_syn != 3'd0);
                    r_out_id   <= r_s1_id;
                end
            end
            if (w_s1_can) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_code <= w_code;
                    r_s1_id   <= w_grant;
                end
            end
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                r_cnt[i] <= '0;
            end
        end else if (clr_count) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_cnt_inc && (r_cnt[r_s1_id] != '1)) begin
            r_cnt[r_s1_id] <= r_cnt[r_s1_id] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_cnt
        assign err_count[CNT_W*g +: CNT_W] = r_cnt[g];
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_syndrome  = r_out_syn;
    assign out_corrected = r_out_corr;
    assign out_id        = r_out_id;

endmodule
